fsm_seq_ctrl: RTL and testbench
===============================

# fsm_seq_ctrl

Test-sequencing controller that sits between the board inputs and the one-hot and binary sequence-detector FSMs. On a start pulse it resets both FSMs, plays a programmed serial pattern into their shared `w` input one bit per clock, and compares their `z` outputs every cycle. It records a trace of `z` and a mismatch count so the two encodings can be checked against each other in lockstep on the board LEDs.

## Interface
Parameters:
- `PATTERN_LEN`, default 16: number of `w` bits played per run; must be ≥2.
- `CNT_W`, default `$clog2(PATTERN_LEN+1)`: width of the mismatch counter.

Ports:
- `clk`  in  1: single clock; all state updates on the rising edge.
- `reset`  in  1: synchronous, active-high; clears the whole block.
- `start`  in  1: run request; sampled only in IDLE or DONE.
- `pattern`  in  PATTERN_LEN: bits applied LSB first; captured on accepted start.
- `z_onehot`  in  1: `z` from the one-hot FSM.
- `z_binary`  in  1: `z` from the binary FSM.
- `w`  out  1: shared serial input to both FSMs.
- `fsm_reset`  out  1: reset to both FSMs; equals `reset` OR (state==CLEAR), combinational.
- `busy`  out  1: high in CLEAR, RUN and DRAIN.
- `done`  out  1: high in DONE.
- `mismatch`  out  1: sticky; set on any compare mismatch in the current run.
- `mismatch_count`  out  CNT_W: number of mismatching compare cycles.
- `first_mis_idx`  out  CNT_W: sample index of the first mismatch; all-ones if none.
- `z_trace`  out  PATTERN_LEN: `z_onehot` samples; bit k is `z` after bits 0..k have been applied.

## Operation
- States: IDLE, CLEAR, RUN, DRAIN, DONE.
- IDLE/DONE to CLEAR on `start`.
  - Capture `pattern` into `pat_q`.
  - Clear `mismatch`, `mismatch_count` and `z_trace`.
  - Set `first_mis_idx` to all-ones.
- CLEAR: lasts exactly one cycle. `fsm_reset`=1 and `w`=0. Then to RUN with `idx`=0.
- RUN: `w`=`pat_q[idx]`. `idx` increments each cycle. After `idx`=PATTERN_LEN-1, go to DRAIN.
- DRAIN: lasts one cycle. `w`=0. Then to DONE.
- DONE: holds all results until `start` or `reset`.
- Sampling (the FSMs are Moore, so `z` lags `w` by one cycle):
  - Samples are taken in RUN cycles with `idx`≥1 (sample s=`idx`-1) and in DRAIN (s=PATTERN_LEN-1).
  - Exactly PATTERN_LEN samples per run.
  - Each sample writes `z_trace[s]`=`z_onehot`.
  - If `z_onehot`≠`z_binary`: `mismatch`←1 and `mismatch_count`+1.
  - `first_mis_idx`←s on the first mismatch only.
- `mismatch_count` cannot overflow: at most PATTERN_LEN compares, and CNT_W covers PATTERN_LEN.
- `start` while `busy` is ignored. It is not queued.
- `start` held high in DONE restarts a run every PATTERN_LEN+3 cycles. This is legal.
- `pattern` changes after capture have no effect on the run in progress.

## Timing
- Reset values:
  - State IDLE.
  - `w`=0, `busy`=0, `done`=0, `mismatch`=0, `mismatch_count`=0.
  - `first_mis_idx`=all-ones, `z_trace`=0.
  - `fsm_reset`=1 while `reset` is high.
- Cycle schedule, with `start` sampled at edge 0:
  - Cycle 1: CLEAR.
  - Cycles 2..PATTERN_LEN+1: RUN; bit k is driven in cycle 2+k.
  - Cycle PATTERN_LEN+2: DRAIN.
  - From cycle PATTERN_LEN+3: DONE.
  - Default PATTERN_LEN: RUN is cycles 2..17, DRAIN is 18, `done` rises at cycle 19.
- Results are final when `done` first reads 1.
- Reset mid-run: the block returns to IDLE at the next edge. The FSMs are reset in the same cycle. Partial results are discarded.
- `w` and all status outputs except `fsm_reset` are registered.

## Structure
- Package `fsm_seq_pkg`:
  - State enum `seq_state_t` (IDLE, CLEAR, RUN, DRAIN, DONE).
  - Localparam `FIRST_MIS_NONE` (all-ones).
- Single module. No sub-module; the counter, trace shift/write and compare are small enough to keep inline.
- Top level: `fsm_reset` drives the reset of both FSM instances. `w` replaces the direct switch connection. `sw` feeds `start`, synchronised externally.

## Test plan
Bench drives `z_onehot`/`z_binary` from a behavioural stub model.
- Reset → all outputs at reset values; `fsm_reset`=1 during reset; IDLE for 5 cycles with `start`=0.
- `pattern`=16'hA5C3, stubs `z_*`=delayed `w` → `w` sequence equals LSB-first 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1 on cycles 2..17. `z_trace`=16'hA5C3, `mismatch`=0, `first_mis_idx`=31, `done` at cycle 19.
- Same run, `z_binary` forced inverted at sample 5 only → `mismatch`=1, `mismatch_count`=1, `first_mis_idx`=5.
- `z_binary` constantly inverted → `mismatch_count`=16, `first_mis_idx`=0.
- `start` pulsed at cycle 8 of a run and `pattern` changed to 0 → ignored; run completes with the original trace; second `start` in DONE clears results and reruns.
- `reset` asserted at cycle 10 → IDLE next edge, results cleared, `fsm_reset`=1 that cycle, new run after release behaves as the second scenario.

Source files
------------

// File: rtl/fsm_seq_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fsm_seq_pkg : shared types for the sequence-detector test sequencer  |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
package fsm_seq_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    RUN   = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } seq_state_t;

  // Truncated to the counter width where used; all-ones means "no mismatch".
  localparam logic [31:0] FIRST_MIS_NONE = 32'hFFFF_FFFF;

endpackage
`default_nettype wire

// File: rtl/fsm_seq_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fsm_seq_ctrl : plays a serial pattern into two detector FSMs and     |
// | compares their z outputs in lockstep.                   rev 1.0      |
// +--------------------------------------------------------------------+
module fsm_seq_ctrl
  import fsm_seq_pkg::*;
#(
  parameter int PATTERN_LEN = 16,
  parameter int CNT_W       = $clog2(PATTERN_LEN + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [PATTERN_LEN-1:0] pattern,
  input  logic                   z_onehot,
  input  logic                   z_binary,
  output logic                   w,
  output logic                   fsm_reset,
  output logic                   busy,
  output logic                   done,
  output logic                   mismatch,
  output logic [CNT_W-1:0]       mismatch_count,
  output logic [CNT_W-1:0]       first_mis_idx,
  output logic [PATTERN_LEN-1:0] z_trace
);

  localparam int               IDX_W    = $clog2(PATTERN_LEN);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PATTERN_LEN - 1);
  localparam logic [CNT_W-1:0] MIS_NONE = CNT_W'(FIRST_MIS_NONE);

  seq_state_t             state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [PATTERN_LEN-1:0] pat_q, pat_d;
  logic                   w_q, w_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   mismatch_q, mismatch_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic [CNT_W-1:0]       first_q, first_d;
  logic [PATTERN_LEN-1:0] trace_q, trace_d;

  logic                   sample_en;
  logic [IDX_W-1:0]       sample_idx;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    pat_d      = pat_q;
    mismatch_d = mismatch_q;
    count_d    = count_q;
    first_d    = first_q;
    trace_d    = trace_q;
    sample_en  = 1'b0;
    sample_idx = '0;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d    = CLEAR;
          pat_d      = pattern;
          mismatch_d = 1'b0;
          count_d    = '0;
          first_d    = MIS_NONE;
          trace_d    = '0;
        end
      end
      CLEAR: begin
        state_d = RUN;
        idx_d   = '0;
      end
      RUN: begin
        // z lags w by one cycle, so the sample seen now belongs to bit idx-1.
        sample_en  = (idx_q != '0);
        sample_idx = idx_q - IDX_W'(1);
        if (idx_q == IDX_LAST) begin
          state_d = DRAIN;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      DRAIN: begin
        sample_en  = 1'b1;
        sample_idx = IDX_LAST;
        state_d    = DONE;
      end
      default: state_d = IDLE;
    endcase

    if (sample_en) begin
      trace_d[sample_idx] = z_onehot;
      if (z_onehot != z_binary) begin
        mismatch_d = 1'b1;
        count_d    = count_q + CNT_W'(1);
        if (!mismatch_q) begin
          first_d = CNT_W'(sample_idx);
        end
      end
    end

    w_d    = (state_d == RUN) ? pat_q[idx_d] : 1'b0;
    busy_d = (state_d == CLEAR) || (state_d == RUN) || (state_d == DRAIN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      pat_q      <= '0;
      w_q        <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      mismatch_q <= 1'b0;
      count_q    <= '0;
      first_q    <= MIS_NONE;
      trace_q    <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      pat_q      <= pat_d;
      w_q        <= w_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      mismatch_q <= mismatch_d;
      count_q    <= count_d;
      first_q    <= first_d;
      trace_q    <= trace_d;
    end
  end

  assign fsm_reset      = reset || (state_q == CLEAR);
  assign w              = w_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign mismatch       = mismatch_q;
  assign mismatch_count = count_q;
  assign first_mis_idx  = first_q;
  assign z_trace        = trace_q;

endmodule
`default_nettype wire

// File: tb/tb_fsm_seq_ctrl.sv
`default_nettype none
// Directed bench for fsm_seq_ctrl; the detector FSMs are replaced by a
// one-cycle-delay stub with optional fault injection on z_binary.
module tb_fsm_seq_ctrl;

  localparam int LEN = 16;
  localparam int CW  = 5;

  logic           clk = 1'b0;
  logic           reset, start;
  logic [LEN-1:0] pattern;
  logic           z_onehot, z_binary;
  logic           w, fsm_reset, busy, done, mismatch;
  logic [CW-1:0]  mismatch_count, first_mis_idx;
  logic [LEN-1:0] z_trace;

  logic           z_stub_q;
  int unsigned    stub_n;
  logic           inject5, inv_all;
  int             tests  = 0;
  int             failed = 0;

  always #5 clk = ~clk;

  fsm_seq_ctrl #(.PATTERN_LEN(LEN), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .start(start), .pattern(pattern),
    .z_onehot(z_onehot), .z_binary(z_binary), .w(w), .fsm_reset(fsm_reset),
    .busy(busy), .done(done), .mismatch(mismatch),
    .mismatch_count(mismatch_count), .first_mis_idx(first_mis_idx),
    .z_trace(z_trace)
  );

  // Stub: z equals the previous w; stub_n==6 is the cycle carrying sample 5.
  always @(posedge clk) begin
    if (fsm_reset) begin
      z_stub_q <= 1'b0;
      stub_n   <= 0;
    end else begin
      z_stub_q <= w;
      stub_n   <= stub_n + 1;
    end
  end

  assign z_onehot = z_stub_q;
  assign z_binary = z_stub_q ^ (inv_all | (inject5 & (stub_n == 6)));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_run(input logic [LEN-1:0] p, input string tag);
    logic [LEN-1:0] ws;
    ws      = '0;
    pattern = p;
    start   = 1'b1;
    tick();
    start   = 1'b0;
    chk({tag, "_clr_fsm_reset"}, 32'(fsm_reset), 32'd1);
    chk({tag, "_clr_busy"}, 32'(busy), 32'd1);
    chk({tag, "_clr_w"}, 32'(w), 32'd0);
    for (int k = 0; k < LEN; k++) begin
      tick();
      ws[k] = w;
    end
    chk({tag, "_w_seq"}, 32'(ws), 32'(p));
    tick();
    chk({tag, "_drain_w"}, 32'(w), 32'd0);
    chk({tag, "_drain_busy_done"}, {30'd0, busy, done}, 32'b10);
    tick();
    chk({tag, "_done_busy_done"}, {30'd0, busy, done}, 32'b01);
  endtask

  initial begin
    reset   = 1'b1;
    start   = 1'b0;
    pattern = '0;
    inject5 = 1'b0;
    inv_all = 1'b0;

    repeat (3) tick();
    chk("rst_fsm_reset", 32'(fsm_reset), 32'd1);
    chk("rst_w_busy_done_mis", {28'd0, w, busy, done, mismatch}, 32'd0);
    chk("rst_count", 32'(mismatch_count), 32'd0);
    chk("rst_first", 32'(first_mis_idx), 32'h1F);
    chk("rst_trace", 32'(z_trace), 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("idle_quiet", {29'd0, fsm_reset, busy, done}, 32'd0);
    end

    // Clean run: trace mirrors the pattern
    do_run(16'hA5C3, "s1");
    chk("s1_trace", 32'(z_trace), 32'hA5C3);
    chk("s1_mis", 32'(mismatch), 32'd0);
    chk("s1_count", 32'(mismatch_count), 32'd0);
    chk("s1_first", 32'(first_mis_idx), 32'h1F);
    repeat (3) tick();
    chk("s1_hold", {15'd0, done, z_trace}, {15'd0, 1'b1, 16'hA5C3});

    // Single injected mismatch at sample 5
    inject5 = 1'b1;
    do_run(16'hA5C3, "s2");
    inject5 = 1'b0;
    chk("s2_trace", 32'(z_trace), 32'hA5C3);
    chk("s2_mis", 32'(mismatch), 32'd1);
    chk("s2_count", 32'(mismatch_count), 32'd1);
    chk("s2_first", 32'(first_mis_idx), 32'd5);

    // Every sample mismatches
    inv_all = 1'b1;
    do_run(16'hA5C3, "s3");
    inv_all = 1'b0;
    chk("s3_mis", 32'(mismatch), 32'd1);
    chk("s3_count", 32'(mismatch_count), 32'd16);
    chk("s3_first", 32'(first_mis_idx), 32'd0);

    // start and pattern change mid-run are ignored
    pattern = 16'hA5C3;
    start   = 1'b1;
    tick();
    start   = 1'b0;
    repeat (7) tick();
    start   = 1'b1;
    pattern = '0;
    tick();
    start   = 1'b0;
    chk("s4_busy_after_start", 32'(busy), 32'd1);
    repeat (9) tick();
    chk("s4_drain", {30'd0, busy, w}, 32'b10);
    tick();
    chk("s4_done", 32'(done), 32'd1);
    chk("s4_trace", 32'(z_trace), 32'hA5C3);
    chk("s4_count", 32'(mismatch_count), 32'd0);
    chk("s4_first", 32'(first_mis_idx), 32'h1F);
    do_run(16'h1234, "s4b");
    chk("s4b_trace", 32'(z_trace), 32'h1234);
    chk("s4b_mis", 32'(mismatch), 32'd0);

    // Reset mid-run discards partial results
    inject5 = 1'b1;
    pattern = 16'hA5C3;
    start   = 1'b1;
    tick();
    start   = 1'b0;
    repeat (9) tick();
    chk("s5_partial_mis", 32'(mismatch), 32'd1);
    reset = 1'b1;
    #1;
    chk("s5_fsm_reset", 32'(fsm_reset), 32'd1);
    tick();
    chk("s5_cleared_flags", {28'd0, w, busy, done, mismatch}, 32'd0);
    chk("s5_cleared_trace", 32'(z_trace), 32'd0);
    chk("s5_cleared_cnt", {16'd0, 3'd0, mismatch_count, 3'd0, first_mis_idx}, {16'd0, 8'd0, 8'h1F});
    reset = 1'b0;
    tick();
    do_run(16'hA5C3, "s5b");
    inject5 = 1'b0;
    chk("s5b_trace", 32'(z_trace), 32'hA5C3);
    chk("s5b_count", 32'(mismatch_count), 32'd1);
    chk("s5b_first", 32'(first_mis_idx), 32'd5);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
`default_nettype wire
